// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider bank.
package clk_div_pkg;

  localparam int MAX_CH    = 8;
  localparam int DEF_DIV_W = 8;

  typedef logic [DEF_DIV_W-1:0] half_t;

  typedef struct packed {
    half_t h;
    half_t cnt;
    logic  o;
    half_t p;
    logic  pend;
  } ch_state_t;

  function automatic logic ch_in_range(input logic [2:0] ch, input int num_ch);
    return int'(ch) < num_ch;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, output toggle, staged divisor
// update applied at the end of a full period, tick strobe and phase-align.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 4
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  typedef struct packed {
    logic [DIV_W-1:0] h;
    logic [DIV_W-1:0] cnt;
    logic             o;
    logic [DIV_W-1:0] p;
    logic             pend;
  } state_t;

  localparam logic [DIV_W-1:0] ONE        = DIV_W'(1);
  localparam logic [DIV_W-1:0] RESET_HALF = DIV_W'(DEFAULT_HALF);

  state_t st_q, st_d;
  logic   tick_q, tick_d;
  logic   wrap;

  assign wrap = (st_q.cnt == st_q.h - ONE);

  always_comb begin
    st_d   = st_q;
    tick_d = 1'b0;
    if (st_q.h == '0) begin
      st_d.cnt = '0;
      st_d.o   = 1'b0;
      if (cfg_we && cfg_half != '0) begin
        st_d.h = cfg_half;
      end
    end else begin
      if (sync) begin
        st_d.cnt = '0;
        st_d.o   = 1'b0;
        if (st_q.pend) begin
          st_d.h    = st_q.p;
          st_d.pend = 1'b0;
        end
      end else if (wrap) begin
        st_d.cnt = '0;
        st_d.o   = ~st_q.o;
        // Falling toggle closes a full period: the only glitch-free apply point.
        if (!st_q.o) begin
          tick_d = 1'b1;
        end else if (st_q.pend) begin
          st_d.h    = st_q.p;
          st_d.pend = 1'b0;
        end
      end else begin
        st_d.cnt = st_q.cnt + ONE;
      end
      // cfg_ready keeps writes away while pend is set, so this never races the apply.
      if (cfg_we) begin
        st_d.p    = cfg_half;
        st_d.pend = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      st_q.h    <= RESET_HALF;
      st_q.cnt  <= '0;
      st_q.o    <= 1'b0;
      st_q.p    <= '0;
      st_q.pend <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      st_q   <= st_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = st_q.o;
  assign tick    = tick_q;
  assign busy    = st_q.pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with a valid/ready config port.
// Define CLK_DIV_PHASE_ALIGN_EN to let the sync input restart all channels in phase.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 4
) (
  input  logic              clk_ref,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half,
  output logic              cfg_err,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [MAX_CH-1:0] busy_ext;
  logic              in_range;
  logic              accept;
  logic              cfg_err_q, cfg_err_d;
  logic              sync_eff;

`ifdef CLK_DIV_PHASE_ALIGN_EN
  assign sync_eff = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_eff    = 1'b0;
`endif

  // Unimplemented channel slots read as never-pending, so out-of-range writes are accepted.
  assign busy_ext  = MAX_CH'(busy);
  assign in_range  = ch_in_range(cfg_ch, NUM_CH);
  assign cfg_ready = ~busy_ext[cfg_ch];
  assign accept    = cfg_valid & cfg_ready;

  always_comb begin
    cfg_err_d = accept & ~in_range;
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we;
    assign we = accept && (cfg_ch == 3'(i));

    clk_div_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_ref  (clk_ref),
      .rst      (rst),
      .cfg_we   (we),
      .cfg_half (cfg_half),
      .sync     (sync_eff),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized self-checking bench for clk_div_bank against a period-position model.
module tb_clk_div_bank;

  localparam int NUM_CH       = 2;
  localparam int DIV_W        = 8;
  localparam int DEFAULT_HALF = 4;

  logic              clk_ref = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_half;
  logic              cfg_err;
  logic              sync;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  clk_div_bank #(
    .NUM_CH       (NUM_CH),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clk_ref   (clk_ref),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_err   (cfg_err),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk_ref = ~clk_ref;

  int total = 0;
  int bad   = 0;

  // Model: per channel, half-period, position within the current period
  // (0..2H-1, output high for positions >= H), staged value and pending flag.
  int mh[8];
  int mpos[8];
  int mstage[8];
  bit mpend[8];
  bit merr;
  bit last_acc;
  bit last_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      mh[c]     = DEFAULT_HALF;
      mpos[c]   = 0;
      mstage[c] = 0;
      mpend[c]  = 1'b0;
    end
    merr = 1'b0;
  endfunction

  function automatic void model_edge(input bit acc, input bit do_sync);
    for (int c = 0; c < NUM_CH; c++) begin
      bit wr;
      wr = acc && (int'(cfg_ch) == c);
      if (mh[c] != 0) begin
        if (do_sync) mpos[c] = 0;
        else begin
          mpos[c]++;
          if (mpos[c] == 2 * mh[c]) mpos[c] = 0;
        end
        if (mpos[c] == 0 && mpend[c]) begin
          mh[c]    = mstage[c];
          mpend[c] = 1'b0;
        end
        if (wr) begin
          mstage[c] = int'(cfg_half);
          mpend[c]  = 1'b1;
        end
      end else if (wr && cfg_half != 0) begin
        mh[c]   = int'(cfg_half);
        mpos[c] = 0;
      end
    end
    merr = acc && (int'(cfg_ch) >= NUM_CH);
  endfunction

  task automatic step();
    bit ready_exp;
    bit do_sync;
    logic [NUM_CH-1:0] eo, et, eb;
    #1;
    ready_exp = !((int'(cfg_ch) < NUM_CH) && mpend[cfg_ch]);
    last_rdy  = cfg_ready;
    check("cfg_ready", cfg_ready, ready_exp);
    @(posedge clk_ref);
    do_sync = 1'b0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    do_sync = sync;
`endif
    last_acc = !rst && cfg_valid && ready_exp;
    if (rst) model_reset();
    else model_edge(last_acc, do_sync);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      eo[c] = (mh[c] != 0) && (mpos[c] >= mh[c]);
      et[c] = (mh[c] != 0) && (mpos[c] == mh[c]);
      eb[c] = mpend[c];
    end
    check("clk_out", clk_out, eo);
    check("tick", tick, et);
    check("busy", busy, eb);
    check("cfg_err", cfg_err, merr);
  endtask

  task automatic wr(input int ch, input int half, output int stalls);
    bit done;
    cfg_ch    = 3'(ch);
    cfg_half  = DIV_W'(half);
    cfg_valid = 1'b1;
    stalls    = 0;
    done      = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      step();
      if (last_acc) done = 1'b1;
      else if (!last_rdy) stalls++;
    end
    if (!done) check("wr_timeout", 0, 1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (!mpend[ch]) done = 1'b1;
      else step();
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int s, s2;
    bit found;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    sync      = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_clk_out", clk_out, 0);
    rst = 1'b0;
    repeat (24) step();

    // Retune ch0 to 2 while its output is high
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (mpos[0] == 5) found = 1'b1;
      else step();
    end
    if (!found) check("phase_timeout", 0, 1);
    wr(0, 2, s);
    check("busy0_after_wr", busy[0], 1);
    repeat (20) step();

    // Disable ch1, let it settle low, then re-enable at 3
    wr(1, 0, s);
    wait_idle(1);
    repeat (6) step();
    check("ch1_disabled_low", clk_out[1], 0);
    wr(1, 3, s);
    repeat (2) step();
    check("ch1_low_before_rise", clk_out[1], 0);
    step();
    check("ch1_rise_3_after", clk_out[1], 1);
    repeat (15) step();

    // Back-to-back writes to ch0: second must stall until the first applies
    wr(0, 3, s);
    wr(0, 5, s2);
    check("second_wr_stalled", (s2 > 0), 1);
    wait_idle(0);
    repeat (25) step();

    // Out-of-range channel
    cfg_ch    = 3'd5;
    cfg_half  = 8'd1;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("err_pulse", cfg_err, 1);
    step();
    check("err_pulse_end", cfg_err, 0);
    repeat (10) step();

`ifdef CLK_DIV_PHASE_ALIGN_EN
    wait_idle(0);
    wr(0, 3, s);
    wait_idle(0);
    wait_idle(1);
    wr(1, 5, s);
    wait_idle(1);
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_low", clk_out, 0);
    repeat (12) step();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(NUM_CH, 7))
                                              : 3'($urandom_range(0, NUM_CH - 1));
      cfg_half  = ($urandom_range(0, 9) == 0) ? '0 : DIV_W'($urandom_range(1, 6));
`ifdef CLK_DIV_PHASE_ALIGN_EN
      sync      = ($urandom_range(0, 40) == 0);
`endif
      step();
    end
    cfg_valid = 1'b0;
    sync      = 1'b0;

    // Stage an update, then reset mid-period: outputs drop immediately
    wait_idle(0);
    wr(0, 6, s);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("rst_async_clk_out", clk_out, 0);
    check("rst_async_tick", tick, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_err", cfg_err, 0);
    model_reset();
    step();
    rst = 1'b0;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of `NUM_CH` independent programmable clock dividers, all driven from one reference clock. It replaces the fixed-ratio divider used for debug/video clocking. Each channel produces:
- a square-wave divided clock;
- a one-cycle tick strobe, usable as a clock enable.

Each channel's divisor is reprogrammable at runtime through a valid/ready config port. A new divisor takes effect only at a period boundary, so the divided clock never glitches.

## Interface
Parameters:
- `NUM_CH`, 2: number of divider channels (1..8).
- `DIV_W`, 8: width of the half-period divisor.
- `DEFAULT_HALF`, 4: half-period loaded into every channel at reset. The value 4 gives clk_ref/8.

Ports:
- `clk_ref`  in  1: reference clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `cfg_valid`  in  1: config write request.
- `cfg_ready`  out  1: config write can be accepted this cycle.
- `cfg_ch`  in  3: target channel index.
- `cfg_half`  in  `DIV_W`: new half-period in clk_ref cycles; 0 disables the channel.
- `cfg_err`  out  1: one-cycle pulse when a write targets `cfg_ch >= NUM_CH`.
- `sync`  in  1: phase-align pulse (used only when `CLK_DIV_PHASE_ALIGN_EN` is defined).
- `clk_out`  out  `NUM_CH`: divided clocks.
- `tick`  out  `NUM_CH`: one-cycle strobe coincident with each rising edge of `clk_out`.
- `busy`  out  `NUM_CH`: channel has a staged update that has not yet been applied.

## Operation
Per-channel state:
- active half-period `H`;
- counter `cnt`, `DIV_W` bits wide;
- output bit `o`;
- staged half-period `P`;
- pending flag `pend`.

Every clk_ref edge, for each channel with `H != 0`:
- If `cnt == H-1`: set `cnt` to 0 and toggle `o`.
  - On a 0->1 toggle, assert `tick` for one cycle.
  - On a 1->0 toggle with `pend` set: load `H` from `P` and clear `pend`.
- Otherwise: increment `cnt`.
- Resulting waveform: `clk_out` period is 2*H cycles at 50% duty.

Channels with `H == 0` hold `o` low, `cnt` at 0 and `tick` low.

Config handshake:
- A write is accepted when `cfg_valid && cfg_ready`.
- `cfg_ready` is low only when `cfg_ch` is a valid index whose `pend` is set. It is combinational from `cfg_ch` and `pend`.
- Write to a disabled channel with a nonzero value: load `H`, set `cnt` and `o` to 0 on the next edge. No staging.
- Write to an active channel: set `P`, set `pend`. The new value is applied at the next falling toggle of `o`, which is the end of a full period.
- Writing 0 to an active channel stages a disable. After the falling edge the output stays low.
- Writing 0 to a disabled channel is a no-op.
- Out-of-range `cfg_ch`: the write is accepted (`cfg_ready` high), no channel changes, and `cfg_err` pulses on the next cycle.

## Timing
Reset values (asynchronous):
- `clk_out` = 0, `tick` = 0, `busy` = 0, `cfg_err` = 0.
- `H` = `DEFAULT_HALF`, `cnt` = 0, `pend` = 0 for every channel.

Latency and edges:
- After reset release, the first rising edge of `clk_out` occurs on edge `DEFAULT_HALF` after release.
- When a disabled channel is enabled at accept edge t, `clk_out` rises at edge t+H.
- `tick` and the rising edge of `clk_out` are registered on the same clk_ref edge.
- `busy` equals `pend`: it rises on the edge after accept and falls on the applying edge.

Boundary cases:
- A staged apply and a new write to the same channel cannot coincide, because `cfg_ready` is low while `pend` is set.
- The counter wraps only at `H-1`. Overflow is impossible because `cnt < H <= 2^DIV_W - 1`.
- Asserting `rst` mid-period immediately forces all outputs low and discards all pending updates.

## Configuration
`CLK_DIV_PHASE_ALIGN_EN`:
- **Defined:** a `sync` high at an edge forces, on that edge, `cnt` = 0 and `o` = 0 in every active channel, so all channels restart phase-aligned.
  - Any pending updates are applied at that same edge.
  - `sync` takes priority over a same-edge toggle.
- **Undefined:** `sync` is ignored and channels run free-phased.

## Structure
- Package `clk_div_pkg` holds:
  - `MAX_CH` = 8;
  - typedef `half_t` (`logic [DIV_W-1:0]` at its default width);
  - the channel state struct (`H`, `cnt`, `o`, `P`, `pend`).
- Sub-module `clk_div_channel` implements one channel: counter, toggle, staging, tick and sync.
- The top level performs:
  - generate instantiation of `NUM_CH` channels;
  - decoding of `cfg_ch`;
  - generation of `cfg_ready` and `cfg_err`.

## Test plan
- Reset with NUM_CH=2 and default parameters -> both `clk_out` toggle every 4 cycles (period 8), and `tick` occurs every 8 cycles in phase with the rising edge.
- While ch0 runs at H=4, write ch0 = 2 mid-high-phase -> `busy[0]` is high until the next falling edge; afterwards the period is 4 with no half-period shorter than 4 before the change.
- Write ch1 = 0, then ch1 = 3 after it has gone low -> `clk_out[1]` stays low once disabled; after the second write it rises 3 cycles after the accept, then has period 6.
- Write to ch0 twice back-to-back -> the second write stalls (`cfg_ready` low) until the first is applied, then is accepted.
- Write with `cfg_ch` = 5 -> `cfg_err` is a one-cycle pulse and both channels are unchanged.
- With the macro defined, ch0 at H=3 and ch1 at H=5, pulse `sync` -> both outputs go low that edge; ch0 rises 3 cycles later and ch1 rises 5 cycles later.
